riscv_multicycle_ctrl: RTL and testbench

Multi-cycle sequencing controller for the RV32 datapath. It owns the fetch/decode/execute/memory/writeback schedule, drives the ALU operation class and the register/PC/memory enables, and performs req/ready handshakes with instruction and data memory. It sits beside the ALU control decoder and consumes the current instruction-register value and the ALU zero flag. It supports the R_Type, I_Type, LW, SW and BEQ opcode classes; any other opcode halts the core.

---
 rtl/riscv_multicycle_ctrl.sv | 221 ++++++++++++++++++++++
 tb/tb_riscv_multicycle_ctrl.sv | 415 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/riscv_multicycle_ctrl.sv
// Multi-cycle sequencing controller for the RV32 datapath.
// Walks each instruction through FETCH/DECODE/EXEC/MEM/WB, and handshakes
// with instruction and data memory using req/ready. While rst is high,
// every output reads as zero. Any opcode outside the supported set parks
// the core in HALT until the next reset.

package riscv_multicycle_pkg;

  typedef logic [31:0] word_t;

  localparam logic [6:0] OPC_R_TYPE = 7'b0110011;
  localparam logic [6:0] OPC_I_TYPE = 7'b0010011;
  localparam logic [6:0] OPC_LW     = 7'b0000011;
  localparam logic [6:0] OPC_SW     = 7'b0100011;
  localparam logic [6:0] OPC_BEQ    = 7'b1100011;

  localparam logic [1:0] ALU_ADD   = 2'b00;
  localparam logic [1:0] ALU_SUB   = 2'b01;
  localparam logic [1:0] ALU_FUNCT = 2'b10;

  typedef enum logic [2:0] {
    ST_FETCH  = 3'd0,
    ST_DECODE = 3'd1,
    ST_EXEC   = 3'd2,
    ST_MEM_RD = 3'd3,
    ST_MEM_WR = 3'd4,
    ST_WB     = 3'd5,
    ST_BRANCH = 3'd6,
    ST_HALT   = 3'd7
  } state_t;

endpackage

module riscv_multicycle_ctrl
  import riscv_multicycle_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] instruction,
  input  logic        zero,
  input  logic        imem_ready,
  input  logic        dmem_ready,
  output logic        imem_req,
  output logic        dmem_req,
  output logic        dmem_we,
  output logic        ir_we,
  output logic        aluout_we,
  output logic [1:0]  alu_op,
  output logic        alu_src_b,
  output logic        reg_we,
  output logic        wb_sel,
  output logic        pc_we,
  output logic        pc_src,
  output logic        retire,
  output logic        illegal,
  output logic [31:0] instret,
  output logic [2:0]  state
);

  state_t     state_q;
  state_t     state_d;
  word_t      instret_q;
  logic       illegal_q;
  logic       illegal_d;

  // Kept as a net so the retire count can be steered combinationally.
  wire [31:0] instret_d;

  logic [6:0] opcode;
  logic       is_r;
  logic       is_i;
  logic       is_lw;
  logic       is_sw;
  logic       is_beq;
  logic       is_legal;

  // Only the opcode field matters to sequencing; the rest belongs to the datapath.
  wire unused_instr_bits = ^instruction[31:7];

  // Classify the opcode held in the instruction register.
  always_comb begin
    opcode   = instruction[6:0];
    is_r     = (opcode == OPC_R_TYPE);
    is_i     = (opcode == OPC_I_TYPE);
    is_lw    = (opcode == OPC_LW);
    is_sw    = (opcode == OPC_SW);
    is_beq   = (opcode == OPC_BEQ);
    is_legal = is_r | is_i | is_lw | is_sw | is_beq;
  end

  // Next-state sequencing; memory states wait for their ready handshake.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_FETCH: begin
        if (imem_ready) begin
          state_d = ST_DECODE;
        end
      end
      ST_DECODE: begin
        if (is_r || is_i || is_lw || is_sw) begin
          state_d = ST_EXEC;
        end else if (is_beq) begin
          state_d = ST_BRANCH;
        end else begin
          state_d = ST_HALT;
        end
      end
      ST_EXEC: begin
        if (is_lw) begin
          state_d = ST_MEM_RD;
        end else if (is_sw) begin
          state_d = ST_MEM_WR;
        end else begin
          state_d = ST_WB;
        end
      end
      ST_MEM_RD: begin
        if (dmem_ready) begin
          state_d = ST_WB;
        end
      end
      ST_MEM_WR: begin
        if (dmem_ready) begin
          state_d = ST_FETCH;
        end
      end
      ST_WB:     state_d = ST_FETCH;
      ST_BRANCH: state_d = ST_FETCH;
      ST_HALT:   state_d = ST_HALT;
      default:   state_d = ST_HALT;
    endcase
  end

  // The illegal flag latches on the DECODE->HALT step and never clears on its own.
  always_comb begin
    illegal_d = illegal_q | ((state_q == ST_DECODE) & ~is_legal);
  end

  // Retire count advances once per retire pulse and wraps naturally.
  assign instret_d = retire ? (instret_q + 32'd1) : instret_q;

  // State, retire counter and sticky illegal flag.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= ST_FETCH;
      instret_q <= '0;
      illegal_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      instret_q <= instret_d;
      illegal_q <= illegal_d;
    end
  end

  // Control outputs decoded from state and opcode; zero throughout reset so
  // an in-flight request drops immediately and no write can complete.
  always_comb begin
    imem_req  = 1'b0;
    dmem_req  = 1'b0;
    dmem_we   = 1'b0;
    ir_we     = 1'b0;
    aluout_we = 1'b0;
    alu_op    = ALU_ADD;
    alu_src_b = 1'b0;
    reg_we    = 1'b0;
    wb_sel    = 1'b0;
    pc_we     = 1'b0;
    pc_src    = 1'b0;
    retire    = 1'b0;
    illegal   = 1'b0;
    if (!rst) begin
      illegal = illegal_q;
      case (state_q)
        ST_FETCH: begin
          imem_req = 1'b1;
          ir_we    = imem_ready;
        end
        ST_EXEC: begin
          aluout_we = 1'b1;
          alu_op    = (is_r || is_i) ? ALU_FUNCT : ALU_ADD;
          alu_src_b = is_i | is_lw | is_sw;
        end
        ST_MEM_RD: begin
          dmem_req = 1'b1;
          dmem_we  = 1'b0;
        end
        ST_MEM_WR: begin
          dmem_req = 1'b1;
          dmem_we  = 1'b1;
          // A store retires on the edge where memory accepts it.
          if (dmem_ready) begin
            pc_we  = 1'b1;
            pc_src = 1'b0;
            retire = 1'b1;
          end
        end
        ST_WB: begin
          reg_we = 1'b1;
          wb_sel = is_lw;
          pc_we  = 1'b1;
          pc_src = 1'b0;
          retire = 1'b1;
        end
        ST_BRANCH: begin
          alu_op    = ALU_SUB;
          alu_src_b = 1'b0;
          pc_we     = 1'b1;
          pc_src    = zero;
          retire    = 1'b1;
        end
        default: begin
        end
      endcase
    end
  end

  assign instret = instret_q;
  assign state   = rst ? 3'd0 : 3'(state_q);

endmodule

// File: tb/tb_riscv_multicycle_ctrl.sv
// Directed bench for riscv_multicycle_ctrl: walks each supported opcode class
// through the schedule with a simple req/ready memory responder and checks
// per-cycle control outputs, latency, reset behaviour and counter wrap.
`timescale 1ns/1ps

module tb_riscv_multicycle_ctrl;

  localparam logic [31:0] I_ADD = 32'h002081B3;
  localparam logic [31:0] I_LW  = 32'h00802283;
  localparam logic [31:0] I_SW  = 32'h00502623;
  localparam logic [31:0] I_BEQ = 32'h00000463;
  localparam logic [31:0] I_BAD = 32'hFFFFFFFF;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] instruction = 32'h0;
  logic        zero = 1'b0;
  logic        imem_ready = 1'b0;
  logic        dmem_ready = 1'b0;
  logic        imem_req, dmem_req, dmem_we, ir_we, aluout_we;
  logic [1:0]  alu_op;
  logic        alu_src_b, reg_we, wb_sel, pc_we, pc_src, retire, illegal;
  logic [31:0] instret;
  logic [2:0]  state;

  int checks = 0;
  int failures = 0;
  logic [31:0] exp_instret = 32'h0;

  typedef struct packed {
    logic [2:0] st;
    logic       imem_req;
    logic       dmem_req;
    logic       dmem_we;
    logic       ir_we;
    logic       aluout_we;
    logic [1:0] alu_op;
    logic       alu_src_b;
    logic       reg_we;
    logic       wb_sel;
    logic       pc_we;
    logic       pc_src;
    logic       retire;
    logic       illegal;
  } snap_t;

  snap_t tr[$];

  riscv_multicycle_ctrl dut (
    .clk(clk), .rst(rst), .instruction(instruction), .zero(zero),
    .imem_ready(imem_ready), .dmem_ready(dmem_ready),
    .imem_req(imem_req), .dmem_req(dmem_req), .dmem_we(dmem_we),
    .ir_we(ir_we), .aluout_we(aluout_we), .alu_op(alu_op),
    .alu_src_b(alu_src_b), .reg_we(reg_we), .wb_sel(wb_sel),
    .pc_we(pc_we), .pc_src(pc_src), .retire(retire), .illegal(illegal),
    .instret(instret), .state(state)
  );

  always #5 clk = ~clk;

  function automatic snap_t take_snap();
    snap_t s;
    s.st        = state;
    s.imem_req  = imem_req;
    s.dmem_req  = dmem_req;
    s.dmem_we   = dmem_we;
    s.ir_we     = ir_we;
    s.aluout_we = aluout_we;
    s.alu_op    = alu_op;
    s.alu_src_b = alu_src_b;
    s.reg_we    = reg_we;
    s.wb_sel    = wb_sel;
    s.pc_we     = pc_we;
    s.pc_src    = pc_src;
    s.retire    = retire;
    s.illegal   = illegal;
    return s;
  endfunction

  // Memory responder: ready rises after 'wait' cycles of a held request.
  // With spurious set, dmem_ready is also driven high while dmem_req is low.
  task automatic run_instr(input logic [31:0] instr, input int imem_wait,
                           input int dmem_wait, input logic z, input bit spurious);
    int icnt;
    int dcnt;
    bit done;
    icnt = 0;
    dcnt = 0;
    done = 0;
    tr.delete();
    instruction = instr;
    zero = z;
    for (int c = 0; c < 40 && !done; c++) begin
      @(negedge clk);
      imem_ready = imem_req && (icnt == imem_wait);
      dmem_ready = dmem_req ? (dcnt == dmem_wait) : spurious;
      if (imem_req) icnt++;
      if (dmem_req) dcnt++;
      #1;
      tr.push_back(take_snap());
      if (retire || state == 3'd7) done = 1;
    end
    checks++;
    if (!done) begin
      failures++;
      $display("FAIL run_timeout instr=%h got no retire/halt within 40 cycles, need one", instr);
    end
    @(posedge clk);
    #1;
    imem_ready = 1'b0;
    dmem_ready = 1'b0;
  endtask

  task automatic test_reset();
    @(negedge clk);
    @(negedge clk);
    #1;
    checks++;
    if ({imem_req, dmem_req, retire, illegal, pc_we, ir_we} !== 6'b0) begin
      failures++;
      $display("FAIL reset_outputs got imem_req=%b dmem_req=%b retire=%b illegal=%b pc_we=%b ir_we=%b need all 0",
               imem_req, dmem_req, retire, illegal, pc_we, ir_we);
    end
    checks++;
    if (state !== 3'd0 || instret !== 32'd0) begin
      failures++;
      $display("FAIL reset_state got state=%0d instret=%0d need 0/0", state, instret);
    end
    rst = 1'b0;
    #1;
    checks++;
    if (imem_req !== 1'b1 || state !== 3'd0) begin
      failures++;
      $display("FAIL reset_first_req got imem_req=%b state=%0d need 1/0", imem_req, state);
    end
    $display("tb: reset released, first fetch requested");
  endtask

  task automatic test_add();
    run_instr(I_ADD, 0, 0, 1'b0, 1'b0);
    exp_instret++;
    checks++;
    if (tr.size() !== 4) begin
      failures++;
      $display("FAIL add_latency got %0d need 4", tr.size());
    end
    checks++;
    if ({tr[0].st, tr[1].st, tr[2].st, tr[3].st} !== {3'd0, 3'd1, 3'd2, 3'd5}) begin
      failures++;
      $display("FAIL add_states got %0d,%0d,%0d,%0d need 0,1,2,5",
               tr[0].st, tr[1].st, tr[2].st, tr[3].st);
    end
    checks++;
    if (tr[0].imem_req !== 1'b1 || tr[0].ir_we !== 1'b1) begin
      failures++;
      $display("FAIL add_fetch got imem_req=%b ir_we=%b need 1/1", tr[0].imem_req, tr[0].ir_we);
    end
    checks++;
    if (tr[2].alu_op !== 2'b10 || tr[2].alu_src_b !== 1'b0 || tr[2].aluout_we !== 1'b1) begin
      failures++;
      $display("FAIL add_exec got alu_op=%b alu_src_b=%b aluout_we=%b need 10/0/1",
               tr[2].alu_op, tr[2].alu_src_b, tr[2].aluout_we);
    end
    checks++;
    if (tr[3].reg_we !== 1'b1 || tr[3].wb_sel !== 1'b0 || tr[3].retire !== 1'b1 ||
        tr[3].pc_we !== 1'b1 || tr[3].pc_src !== 1'b0) begin
      failures++;
      $display("FAIL add_wb got reg_we=%b wb_sel=%b retire=%b pc_we=%b pc_src=%b need 1/0/1/1/0",
               tr[3].reg_we, tr[3].wb_sel, tr[3].retire, tr[3].pc_we, tr[3].pc_src);
    end
    checks++;
    if (instret !== exp_instret) begin
      failures++;
      $display("FAIL add_instret got %0d need %0d", instret, exp_instret);
    end
    $display("tb: add x3,x1,x2 cycles=%0d instret=%0d", tr.size(), instret);
  endtask

  task automatic test_lw();
    int rd_cycles;
    rd_cycles = 0;
    run_instr(I_LW, 0, 3, 1'b0, 1'b1);
    exp_instret++;
    foreach (tr[i]) if (tr[i].st == 3'd3) rd_cycles++;
    checks++;
    if (tr.size() !== 8 || rd_cycles !== 4) begin
      failures++;
      $display("FAIL lw_latency got total=%0d mem_rd=%0d need 8/4", tr.size(), rd_cycles);
    end
    checks++;
    if (tr[2].alu_op !== 2'b00 || tr[2].alu_src_b !== 1'b1) begin
      failures++;
      $display("FAIL lw_exec got alu_op=%b alu_src_b=%b need 00/1", tr[2].alu_op, tr[2].alu_src_b);
    end
    checks++;
    if (tr[3].st !== 3'd3 || tr[3].dmem_req !== 1'b1 || tr[3].dmem_we !== 1'b0) begin
      failures++;
      $display("FAIL lw_memrd got state=%0d dmem_req=%b dmem_we=%b need 3/1/0",
               tr[3].st, tr[3].dmem_req, tr[3].dmem_we);
    end
    checks++;
    if (tr[7].st !== 3'd5 || tr[7].wb_sel !== 1'b1 || tr[7].reg_we !== 1'b1 || tr[7].retire !== 1'b1) begin
      failures++;
      $display("FAIL lw_wb got state=%0d wb_sel=%b reg_we=%b retire=%b need 5/1/1/1",
               tr[7].st, tr[7].wb_sel, tr[7].reg_we, tr[7].retire);
    end
    checks++;
    if (instret !== exp_instret) begin
      failures++;
      $display("FAIL lw_instret got %0d need %0d", instret, exp_instret);
    end
    $display("tb: lw x5,8(x0) cycles=%0d mem_rd=%0d instret=%0d", tr.size(), rd_cycles, instret);
  endtask

  task automatic test_sw();
    logic any_reg_we;
    any_reg_we = 1'b0;
    run_instr(I_SW, 0, 0, 1'b0, 1'b0);
    exp_instret++;
    foreach (tr[i]) any_reg_we |= tr[i].reg_we;
    checks++;
    if (tr.size() !== 4 || tr[3].st !== 3'd4) begin
      failures++;
      $display("FAIL sw_latency got total=%0d last_state=%0d need 4/4", tr.size(), tr[3].st);
    end
    checks++;
    if (tr[3].dmem_req !== 1'b1 || tr[3].dmem_we !== 1'b1 || tr[3].retire !== 1'b1 ||
        tr[3].pc_we !== 1'b1 || tr[3].pc_src !== 1'b0) begin
      failures++;
      $display("FAIL sw_memwr got dmem_req=%b dmem_we=%b retire=%b pc_we=%b pc_src=%b need 1/1/1/1/0",
               tr[3].dmem_req, tr[3].dmem_we, tr[3].retire, tr[3].pc_we, tr[3].pc_src);
    end
    checks++;
    if (any_reg_we !== 1'b0 || tr[2].alu_src_b !== 1'b1) begin
      failures++;
      $display("FAIL sw_regwe got reg_we_seen=%b exec_src_b=%b need 0/1", any_reg_we, tr[2].alu_src_b);
    end
    checks++;
    if (instret !== exp_instret) begin
      failures++;
      $display("FAIL sw_instret got %0d need %0d", instret, exp_instret);
    end
    $display("tb: sw x5,12(x0) cycles=%0d instret=%0d", tr.size(), instret);
  endtask

  task automatic test_beq(input logic z);
    run_instr(I_BEQ, 0, 0, z, 1'b0);
    exp_instret++;
    checks++;
    if (tr.size() !== 3 || tr[2].st !== 3'd6) begin
      failures++;
      $display("FAIL beq_latency zero=%b got total=%0d last_state=%0d need 3/6", z, tr.size(), tr[2].st);
    end
    checks++;
    if (tr[2].pc_src !== z || tr[2].pc_we !== 1'b1 || tr[2].alu_op !== 2'b01 ||
        tr[2].alu_src_b !== 1'b0 || tr[2].retire !== 1'b1) begin
      failures++;
      $display("FAIL beq_branch zero=%b got pc_src=%b pc_we=%b alu_op=%b src_b=%b retire=%b need %b/1/01/0/1",
               z, tr[2].pc_src, tr[2].pc_we, tr[2].alu_op, tr[2].alu_src_b, tr[2].retire, z);
    end
    checks++;
    if (instret !== exp_instret) begin
      failures++;
      $display("FAIL beq_instret got %0d need %0d", instret, exp_instret);
    end
    $display("tb: beq zero=%b cycles=%0d pc_src=%b", z, tr.size(), tr[2].pc_src);
  endtask

  task automatic test_back_to_back();
    int retires;
    run_instr(I_ADD, 2, 0, 1'b0, 1'b0);
    exp_instret++;
    retires = 0;
    foreach (tr[i]) if (tr[i].retire) retires++;
    checks++;
    if (tr.size() !== 6 || retires !== 1) begin
      failures++;
      $display("FAIL b2b_add_wait got total=%0d retires=%0d need 6/1", tr.size(), retires);
    end
    run_instr(I_LW, 1, 1, 1'b0, 1'b0);
    exp_instret++;
    retires = 0;
    foreach (tr[i]) if (tr[i].retire) retires++;
    checks++;
    if (tr.size() !== 7 || retires !== 1) begin
      failures++;
      $display("FAIL b2b_lw_wait got total=%0d retires=%0d need 7/1", tr.size(), retires);
    end
    checks++;
    if (instret !== exp_instret) begin
      failures++;
      $display("FAIL b2b_instret got %0d need %0d", instret, exp_instret);
    end
    $display("tb: back-to-back add/lw with waits instret=%0d", instret);
  endtask

  task automatic test_reset_mid_write();
    instruction = I_SW;
    @(negedge clk); imem_ready = 1'b1;
    @(negedge clk); imem_ready = 1'b0;
    @(negedge clk);
    @(negedge clk); dmem_ready = 1'b0;
    #1;
    checks++;
    if (state !== 3'd4 || dmem_req !== 1'b1) begin
      failures++;
      $display("FAIL rstwr_setup got state=%0d dmem_req=%b need 4/1", state, dmem_req);
    end
    #1;
    rst = 1'b1;
    dmem_ready = 1'b1;
    #1;
    checks++;
    if (dmem_req !== 1'b0 || retire !== 1'b0 || pc_we !== 1'b0 || state !== 3'd0 || instret !== 32'd0) begin
      failures++;
      $display("FAIL rstwr_drop got dmem_req=%b retire=%b pc_we=%b state=%0d instret=%0d need 0/0/0/0/0",
               dmem_req, retire, pc_we, state, instret);
    end
    @(posedge clk);
    #1;
    checks++;
    if (state !== 3'd0 || instret !== 32'd0 || dmem_req !== 1'b0) begin
      failures++;
      $display("FAIL rstwr_hold got state=%0d instret=%0d dmem_req=%b need 0/0/0", state, instret, dmem_req);
    end
    @(negedge clk);
    rst = 1'b0;
    dmem_ready = 1'b0;
    exp_instret = 32'd0;
    #1;
    checks++;
    if (imem_req !== 1'b1 || dmem_req !== 1'b0) begin
      failures++;
      $display("FAIL rstwr_restart got imem_req=%b dmem_req=%b need 1/0", imem_req, dmem_req);
    end
    $display("tb: reset during MEM_WR dropped request, instret=%0d", instret);
  endtask

  task automatic test_wrap();
    @(negedge clk);
    imem_ready = 1'b0;
    force dut.instret_d = 32'hFFFFFFFF;
    @(posedge clk);
    #1;
    release dut.instret_d;
    exp_instret = 32'hFFFFFFFF;
    checks++;
    if (instret !== exp_instret) begin
      failures++;
      $display("FAIL wrap_preload got %h need %h", instret, exp_instret);
    end
    run_instr(I_ADD, 0, 0, 1'b0, 1'b0);
    exp_instret++;
    checks++;
    if (instret !== 32'd0 || exp_instret !== 32'd0) begin
      failures++;
      $display("FAIL wrap_instret got %h need 00000000", instret);
    end
    $display("tb: instret wrap -> %h", instret);
  endtask

  task automatic test_illegal();
    int bad_cycles;
    run_instr(I_BAD, 0, 0, 1'b0, 1'b0);
    checks++;
    if (tr.size() !== 3 || tr[2].st !== 3'd7 || tr[2].illegal !== 1'b1 || tr[1].illegal !== 1'b0) begin
      failures++;
      $display("FAIL illegal_entry got total=%0d state=%0d illegal=%b decode_illegal=%b need 3/7/1/0",
               tr.size(), tr[2].st, tr[2].illegal, tr[1].illegal);
    end
    bad_cycles = 0;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      imem_ready = 1'b1;
      dmem_ready = 1'b1;
      #1;
      if (imem_req !== 1'b0 || dmem_req !== 1'b0 || illegal !== 1'b1 || retire !== 1'b0 ||
          pc_we !== 1'b0 || state !== 3'd7 || instret !== exp_instret) bad_cycles++;
    end
    checks++;
    if (bad_cycles !== 0) begin
      failures++;
      $display("FAIL illegal_hold got %0d bad cycles of 20 (imem_req=%b illegal=%b instret=%0d) need 0",
               bad_cycles, imem_req, illegal, instret);
    end
    imem_ready = 1'b0;
    dmem_ready = 1'b0;
    rst = 1'b1;
    #1;
    checks++;
    if (illegal !== 1'b0 || state !== 3'd0) begin
      failures++;
      $display("FAIL illegal_clear got illegal=%b state=%0d need 0/0", illegal, state);
    end
    @(negedge clk);
    rst = 1'b0;
    $display("tb: illegal opcode halted core for 20 cycles, bad=%0d", bad_cycles);
  endtask

  initial begin
    test_reset();
    test_add();
    test_lw();
    test_sw();
    test_beq(1'b1);
    test_beq(1'b0);
    test_back_to_back();
    test_reset_mid_write();
    test_wrap();
    test_illegal();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
